// File: rtl/led_pattern_engine.sv
// ---------------------------------------------------------------------------
// led_pattern_engine
//
// Parametrised LED pattern generator. A prescaler divides clk down to a base
// tick, a runtime speed divider thins the base ticks into pattern steps, and
// the active mode turns its pattern state into the LED drive. Modes:
// OFF, BLINK, COUNT, BOUNCE, RING, FILL, BREATHE (PWM) and a reserved code
// that behaves as OFF. A change on the mode input restarts the pattern
// cleanly from its initial state.
//
// Optional build macro: LED_BRIGHTNESS_EN
//   When defined, a brightness input is added and every LED output is gated
//   with (pwm_cnt < brightness). When undefined, led is the raw pattern.
//
// Ports:
//   clk        in   1         system clock
//   rst        in   1         synchronous active-high reset
//   mode       in   3         pattern select
//   speed      in   2         one pattern step per 2^speed base ticks
//   hold       in   1         1 = freeze pattern state and led
//   brightness in   PWM_BITS  global brightness (LED_BRIGHTNESS_EN only)
//   led        out  NUM_LEDS  registered LED drive
//   step       out  1         one-cycle strobe on the edge the pattern advances
//   dbg_mode   out  3         registered copy of the active mode
//   dbg_pos    out  6         position / count / duty index of active pattern
//
// Handshake: there is no valid/ready traffic; every input is sampled on each
// rising clk edge and every output is a register that changes only on it.
// ---------------------------------------------------------------------------
module led_pattern_engine #(
    parameter int NUM_LEDS  = 8,
    parameter int CLK_FREQ  = 100_000_000,
    parameter int STEP_HZ   = 10,
    parameter int PWM_BITS  = 8,
    parameter int DUTY_STEP = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          mode,
    input  logic [1:0]          speed,
    input  logic                hold,
`ifdef LED_BRIGHTNESS_EN
    input  logic [PWM_BITS-1:0] brightness,
`endif
    output logic [NUM_LEDS-1:0] led,
    output logic                step,
    output logic [2:0]          dbg_mode,
    output logic [5:0]          dbg_pos
);

    localparam int STEP_DIV = CLK_FREQ / STEP_HZ;
    localparam int PW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [PWM_BITS:0]   DUTY_INC = (PWM_BITS + 1)'(DUTY_STEP);

    localparam logic [5:0] POS_LAST = 6'(NUM_LEDS - 1);
    localparam logic [5:0] FILL_TOP = 6'(NUM_LEDS);

    // Widths used to squeeze count / duty into the 6-bit debug position.
    localparam int CW = (NUM_LEDS < 6) ? NUM_LEDS : 6;
    localparam int DW = (PWM_BITS < 6) ? PWM_BITS : 6;

    typedef enum logic [2:0] {
        M_OFF     = 3'd0,
        M_BLINK   = 3'd1,
        M_COUNT   = 3'd2,
        M_BOUNCE  = 3'd3,
        M_RING    = 3'd4,
        M_FILL    = 3'd5,
        M_BREATHE = 3'd6,
        M_RSVD    = 3'd7
    } mode_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    mode_t                mode_q;
    logic [PW-1:0]        presc_q;
    logic [2:0]           div_q;
    logic                 blink_q;
    logic [NUM_LEDS-1:0]  cnt_q;
    logic [5:0]           pos_q;     // BOUNCE/RING position, FILL count
    logic                 dir_q;     // 0 = up, 1 = down
    logic [PWM_BITS-1:0]  duty_q;
    logic [PWM_BITS-1:0]  pwm_cnt;

    // -----------------------------------------------------------------------
    // Timing: prescaler, speed divider, restart detection
    // -----------------------------------------------------------------------
    logic       base_tick;
    logic [3:0] modulus;
    logic       div_over;
    logic       div_done;
    logic       restart;
    logic       advance;
    mode_t      mode_n;

    assign base_tick = (presc_q == PRESC_LAST);
    assign modulus   = 4'd1 << speed;
    // A speed change can leave the divider past its new modulus; that value
    // is discarded rather than allowed to produce a step.
    assign div_over  = ({1'b0, div_q} >= modulus);
    assign div_done  = base_tick && !div_over && ({1'b0, div_q} == (modulus - 4'd1));
    assign restart   = (mode_t'(mode) != mode_q);
    assign advance   = div_done && !hold && !restart;
    assign mode_n    = restart ? mode_t'(mode) : mode_q;

    // -----------------------------------------------------------------------
    // Next pattern state
    // -----------------------------------------------------------------------
    logic                blink_n;
    logic [NUM_LEDS-1:0] cnt_n;
    logic [5:0]          pos_n;
    logic                dir_n;
    logic [PWM_BITS-1:0] duty_n;

    always_comb begin
        blink_n = blink_q;
        cnt_n   = cnt_q;
        pos_n   = pos_q;
        dir_n   = dir_q;
        duty_n  = duty_q;
        if (restart) begin
            blink_n = 1'b0;
            cnt_n   = '0;
            pos_n   = '0;
            dir_n   = 1'b0;
            duty_n  = '0;
        end else if (advance) begin
            case (mode_q)
                M_BLINK: blink_n = ~blink_q;
                M_COUNT: cnt_n = cnt_q + 1'b1;
                M_BOUNCE: begin
                    // Direction flips on the step that lands on an end,
                    // so neither end is shown twice.
                    if (!dir_q) begin
                        pos_n = pos_q + 6'd1;
                        if ((pos_q + 6'd1) == POS_LAST) dir_n = 1'b1;
                    end else begin
                        pos_n = pos_q - 6'd1;
                        if (pos_q == 6'd1) dir_n = 1'b0;
                    end
                end
                M_RING: pos_n = (pos_q == POS_LAST) ? 6'd0 : pos_q + 6'd1;
                M_FILL: begin
                    if (!dir_q) begin
                        pos_n = pos_q + 6'd1;
                        if ((pos_q + 6'd1) == FILL_TOP) dir_n = 1'b1;
                    end else begin
                        pos_n = pos_q - 6'd1;
                        if (pos_q == 6'd1) dir_n = 1'b0;
                    end
                end
                M_BREATHE: begin
                    // Saturate at the rails and turn around on that step.
                    if (!dir_q) begin
                        if (({1'b0, duty_q} + DUTY_INC) >= {1'b0, DUTY_MAX}) begin
                            duty_n = DUTY_MAX;
                            dir_n  = 1'b1;
                        end else begin
                            duty_n = duty_q + DUTY_INC[PWM_BITS-1:0];
                        end
                    end else begin
                        if ({1'b0, duty_q} <= DUTY_INC) begin
                            duty_n = '0;
                            dir_n  = 1'b0;
                        end else begin
                            duty_n = duty_q - DUTY_INC[PWM_BITS-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Pattern and debug position derived from the next state, so led and
    // dbg_pos change on the same edge as the step strobe.
    // -----------------------------------------------------------------------
    logic [NUM_LEDS-1:0] pat_n;
    logic [5:0]          dbg_pos_n;
    logic                pwm_on;

    assign pwm_on = (pwm_cnt < duty_q);

    always_comb begin
        pat_n     = '0;
        dbg_pos_n = '0;
        case (mode_n)
            M_BLINK: pat_n = {NUM_LEDS{blink_n}};
            M_COUNT: begin
                pat_n     = cnt_n;
                dbg_pos_n = 6'(cnt_n[CW-1:0]);
            end
            M_BOUNCE, M_RING: begin
                for (int i = 0; i < NUM_LEDS; i++) pat_n[i] = (pos_n == 6'(i));
                dbg_pos_n = pos_n;
            end
            M_FILL: begin
                for (int i = 0; i < NUM_LEDS; i++) pat_n[i] = (6'(i) < pos_n);
                dbg_pos_n = pos_n;
            end
            M_BREATHE: begin
                // PWM compare uses the duty held before this edge; on the
                // restart edge the duty is zero so all LEDs start dark.
                pat_n     = restart ? '0 : {NUM_LEDS{pwm_on}};
                dbg_pos_n = 6'(duty_n[PWM_BITS-1 -: DW]) << (6 - DW);
            end
            default: ;
        endcase
    end

    logic [NUM_LEDS-1:0] led_n;
`ifdef LED_BRIGHTNESS_EN
    assign led_n = pat_n & {NUM_LEDS{(pwm_cnt < brightness)}};
`else
    assign led_n = pat_n;
`endif

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= M_OFF;
            presc_q <= '0;
            div_q   <= '0;
            blink_q <= 1'b0;
            cnt_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            duty_q  <= '0;
            pwm_cnt <= '0;
            led     <= '0;
            step    <= 1'b0;
            dbg_pos <= '0;
        end else begin
            // PWM counter free-runs through hold and restart.
            pwm_cnt <= pwm_cnt + 1'b1;
            mode_q  <= mode_n;

            if (restart) begin
                presc_q <= '0;
                div_q   <= '0;
            end else begin
                presc_q <= base_tick ? '0 : presc_q + 1'b1;
                if (div_over) begin
                    div_q <= '0;
                end else if (base_tick) begin
                    div_q <= div_done ? 3'd0 : div_q + 3'd1;
                end
            end

            step    <= advance;
            blink_q <= blink_n;
            cnt_q   <= cnt_n;
            pos_q   <= pos_n;
            dir_q   <= dir_n;
            duty_q  <= duty_n;
            led     <= led_n;
            dbg_pos <= dbg_pos_n;
        end
    end

    assign dbg_mode = mode_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_engine
//
// Bench for led_pattern_engine with NUM_LEDS=4, CLK_FREQ=100, STEP_HZ=10,
// PWM_BITS=4, DUTY_STEP=4. A reference model tracks the number of steps since
// the last restart and derives each mode's pattern from that count; every
// cycle the DUT outputs are compared against it. Directed sequences and a
// table of mode/speed/hold records add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_led_pattern_engine;

    localparam int N     = 4;
    localparam int PB    = 4;
    localparam int DSTEP = 4;
    localparam int DIV   = 10;
    localparam int DMAX  = (1 << PB) - 1;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   mode = 3'd0;
    logic [1:0]   speed = 2'd0;
    logic         hold = 1'b0;
`ifdef LED_BRIGHTNESS_EN
    logic [PB-1:0] brightness = '1;
`endif
    logic [N-1:0] led;
    logic         step;
    logic [2:0]   dbg_mode;
    logic [5:0]   dbg_pos;

    always #5 clk = ~clk;

    led_pattern_engine #(
        .NUM_LEDS (N),
        .CLK_FREQ (100),
        .STEP_HZ  (10),
        .PWM_BITS (PB),
        .DUTY_STEP(DSTEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .speed     (speed),
        .hold      (hold),
`ifdef LED_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .led       (led),
        .step      (step),
        .dbg_mode  (dbg_mode),
        .dbg_pos   (dbg_pos)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters
    // ------------------------------------------------------------------
    int errors = 0;
    int checks = 0;
    logic [N-1:0] exp_q[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model: pattern as a function of steps since restart
    // ------------------------------------------------------------------
    int           m_mode = 0, m_presc = 0, m_div = 0, m_k = 0, m_pwm = 0;
    logic [N-1:0] m_led = '0;
    logic         m_step = 1'b0;
    logic [5:0]   m_pos = '0;
    bit           m_gate = 1'b1;

    function automatic int duty_at(int k);
        int d = 0;
        bit up = 1'b1;
        for (int i = 0; i < k; i++) begin
            if (up) begin
                if (d + DSTEP >= DMAX) begin d = DMAX; up = 1'b0; end
                else d = d + DSTEP;
            end else begin
                if (d <= DSTEP) begin d = 0; up = 1'b1; end
                else d = d - DSTEP;
            end
        end
        return d;
    endfunction

    function automatic int pos_of(int md, int k);
        int m;
        case (md)
            2: return k % (1 << N);
            3: begin m = k % (2 * (N - 1)); return (m <= N - 1) ? m : 2 * (N - 1) - m; end
            4: return k % N;
            5: begin m = k % (2 * N); return (m <= N) ? m : 2 * N - m; end
            6: return duty_at(k) << (6 - PB);
            default: return 0;
        endcase
    endfunction

    function automatic logic [N-1:0] pat_of(int md, int k);
        logic [N-1:0] r = '0;
        int p = pos_of(md, k);
        case (md)
            1: r = (k % 2 == 1) ? '1 : '0;
            2: r = N'(p);
            3, 4: r[p] = 1'b1;
            5: for (int i = 0; i < N; i++) r[i] = (i < p);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Literal LED expectations, masked by the brightness gate when present.
    function automatic logic [N-1:0] gl(logic [N-1:0] v);
        return m_gate ? v : '0;
    endfunction

    task automatic model_edge();
        int  pwm_old = m_pwm;
        int  modl;
        bit  tick, fire;
        if (rst) begin
            m_mode = 0; m_presc = 0; m_div = 0; m_k = 0; m_pwm = 0;
            m_led = '0; m_step = 1'b0; m_pos = '0; m_gate = 1'b1;
            return;
        end
`ifdef LED_BRIGHTNESS_EN
        m_gate = (pwm_old < int'(brightness));
`else
        m_gate = 1'b1;
`endif
        m_pwm = (m_pwm + 1) % (1 << PB);
        if (int'(mode) != m_mode) begin
            m_mode = int'(mode); m_presc = 0; m_div = 0; m_k = 0; m_step = 1'b0;
            m_led = (m_mode == 6) ? '0 : gl(pat_of(m_mode, 0));
            m_pos = 6'(pos_of(m_mode, 0));
            return;
        end
        tick    = (m_presc == DIV - 1);
        m_presc = tick ? 0 : m_presc + 1;
        modl    = 1 << speed;
        fire    = 1'b0;
        if (m_div >= modl) m_div = 0;
        else if (tick) begin
            if (m_div == modl - 1) begin m_div = 0; fire = 1'b1; end
            else m_div++;
        end
        m_step = fire && !hold;
        if (m_mode == 6) m_led = gl((pwm_old < duty_at(m_k)) ? '1 : '0);
        if (m_step) m_k++;
        if (m_mode != 6) m_led = gl(pat_of(m_mode, m_k));
        m_pos = 6'(pos_of(m_mode, m_k));
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("led", led, m_led);
        chk("step", step, m_step);
        chk("dbg_mode", dbg_mode, m_mode);
        chk("dbg_pos", dbg_pos, m_pos);
    endtask

    task automatic wait_step(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!step && cyc < 400);
        if (!step) chk("step_timeout", step, 1);
    endtask

    typedef struct {
        logic [2:0]   md;
        logic [1:0]   sp;
        logic         hd;
        int           n;
        logic [N-1:0] el;
        logic [5:0]   ep;
    } vec_t;

    vec_t tbl[14];

    int c, nst, hi;
    int d8, d15, d11;

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        tbl[0]  = '{3'd1, 2'd0, 1'b0, 36, 4'b1111, 6'd0};
        tbl[1]  = '{3'd2, 2'd0, 1'b0, 36, 4'b0011, 6'd3};
        tbl[2]  = '{3'd3, 2'd0, 1'b0, 36, 4'b1000, 6'd3};
        tbl[3]  = '{3'd4, 2'd0, 1'b0, 36, 4'b1000, 6'd3};
        tbl[4]  = '{3'd5, 2'd0, 1'b0, 36, 4'b0111, 6'd3};
        tbl[5]  = '{3'd7, 2'd0, 1'b0, 36, 4'b0000, 6'd0};
        tbl[6]  = '{3'd0, 2'd0, 1'b0, 36, 4'b0000, 6'd0};
        tbl[7]  = '{3'd3, 2'd0, 1'b0, 56, 4'b0010, 6'd1};
        tbl[8]  = '{3'd4, 2'd0, 1'b0, 56, 4'b0010, 6'd1};
        tbl[9]  = '{3'd5, 2'd0, 1'b0, 56, 4'b0111, 6'd3};
        tbl[10] = '{3'd2, 2'd0, 1'b0, 56, 4'b0101, 6'd5};
        tbl[11] = '{3'd1, 2'd0, 1'b0, 56, 4'b1111, 6'd0};
        tbl[12] = '{3'd2, 2'd1, 1'b0, 56, 4'b0010, 6'd2};
        tbl[13] = '{3'd4, 2'd0, 1'b1, 36, 4'b0001, 6'd0};

        // Reset with COUNT selected.
        rst = 1'b1; mode = 3'd2;
        repeat (3) tick();
        chk("rst_led", led, 0);
        chk("rst_step", step, 0);
        chk("rst_dbg_mode", dbg_mode, 0);
        chk("rst_dbg_pos", dbg_pos, 0);

        // COUNT: first step gives 0001, 16 steps wrap to 0000.
        rst = 1'b0;
        wait_step(c);
        chk("count_first", led, gl(4'b0001));
        for (int i = 1; i < 16; i++) begin
            wait_step(c);
            chk("count_spacing", c, 10);
        end
        chk("count_wrap", led, gl(4'b0000));

        // BOUNCE at speed 0.
        mode = 3'd3;
        tick();
        chk("bounce_init", led, gl(4'b0001));
        exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
        while (exp_q.size() > 0) begin
            wait_step(c);
            chk("bounce_led", led, gl(exp_q.pop_front()));
            chk("bounce_spacing", c, 10);
        end

        // RING at speed 2: one step per 40 cycles.
        speed = 2'd2; mode = 3'd4;
        tick();
        exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        while (exp_q.size() > 0) begin
            wait_step(c);
            chk("ring_led", led, gl(exp_q.pop_front()));
            chk("ring_spacing", c, 40);
        end

        // Hold in COUNT at value 5.
        speed = 2'd0; mode = 3'd2;
        tick();
        repeat (5) wait_step(c);
        chk("hold_pre", led, gl(4'b0101));
        hold = 1'b1;
        nst = 0;
        repeat (50) begin
            tick();
            if (step) nst++;
        end
        chk("hold_steps", nst, 0);
        chk("hold_led", led, gl(4'b0101));
        hold = 1'b0;
        wait_step(c);
        chk("hold_release", led, gl(4'b0110));

        // Mode change 3 -> 5 mid-prescale.
        mode = 3'd3;
        tick();
        repeat (4) tick();
        mode = 3'd5;
        tick();
        chk("fill_restart_led", led, 0);
        chk("fill_restart_step", step, 0);
        wait_step(c);
        chk("fill_first_spacing", c, 10);
        chk("fill_first", led, gl(4'b0001));
        exp_q = '{4'b0011, 4'b0111, 4'b1111, 4'b0111};
        while (exp_q.size() > 0) begin
            wait_step(c);
            chk("fill_led", led, gl(exp_q.pop_front()));
        end

        // BREATHE at speed 3 so a full 16-cycle PWM window fits between steps.
`ifdef LED_BRIGHTNESS_EN
        brightness = 4'd3;
        d8 = 3; d15 = 3; d11 = 3;
`else
        d8 = 8; d15 = 15; d11 = 11;
`endif
        speed = 2'd3; mode = 3'd6;
        tick();
        repeat (2) wait_step(c);
        chk("breathe_pos8", dbg_pos, 32);
        repeat (2) tick();
        hi = 0;
        repeat (16) begin tick(); hi += int'(led[0]); end
        chk("breathe_duty8", hi, d8);
        repeat (2) wait_step(c);
        chk("breathe_pos15", dbg_pos, 60);
        repeat (2) tick();
        hi = 0;
        repeat (16) begin tick(); hi += int'(led[3]); end
        chk("breathe_duty15", hi, d15);
        wait_step(c);
        chk("breathe_pos11", dbg_pos, 44);
        repeat (2) tick();
        hi = 0;
        repeat (16) begin tick(); hi += int'(led[1]); end
        chk("breathe_duty11", hi, d11);
`ifdef LED_BRIGHTNESS_EN
        brightness = '1;
`endif

        // Table-driven mode/speed/hold records.
        speed = 2'd0; mode = 3'd0;
        repeat (2) tick();
        foreach (tbl[i]) begin
            mode = tbl[i].md; speed = tbl[i].sp; hold = tbl[i].hd;
            repeat (tbl[i].n) tick();
            chk("tbl_led", led, gl(tbl[i].el));
            chk("tbl_pos", dbg_pos, tbl[i].ep);
            chk("tbl_mode", dbg_mode, tbl[i].md);
        end
        hold = 1'b0;

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 59) == 0) mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 79) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) hold = ~hold;
`ifdef LED_BRIGHTNESS_EN
            if ($urandom_range(0, 99) == 0) brightness = PB'($urandom);
`endif
        end
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
